// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: sequences the edge/bit counter, sampler, deserializer
// and frame checkers, and pulses data_valid once for every error-free frame.
module uart_rx_fsm #(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic [4:0] edge_count,
    input  logic [3:0] bit_count,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       counter_enable,
    output logic       data_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       par_error,
    output logic       stp_error,
    output logic [2:0] fsm_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    logic       par_en_q;
    logic       glitch_q;
    logic       p_legal;
    logic [5:0] edge_ext;
    logic [5:0] half;
    logic [5:0] pre_chk;
    logic [5:0] res_chk;
    logic [5:0] end_cnt;
    logic       at_pre_chk;
    logic       at_res;
    logic       at_end;
    logic [3:0] stop_idx;
    logic       in_data_bits;
    logic       glitch_now;
    logic       stp_now;

    always_comb begin
        p_legal      = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
        edge_ext     = {1'b0, edge_count};
        half         = {1'b0, Prescale[5:1]};
        // Strobes are registered: decode one count early so they are high at CHK,
        // and the checker answers one count after CHK.
        pre_chk      = half + 6'd1;
        res_chk      = half + 6'd3;
        end_cnt      = Prescale - 6'd1;
        at_pre_chk   = (edge_ext == pre_chk);
        at_res       = (edge_ext == res_chk);
        at_end       = (edge_ext == end_cnt);
        stop_idx     = par_en_q ? 4'(DATA_BITS + 2) : 4'(DATA_BITS + 1);
        in_data_bits = (bit_count >= 4'd1) && (bit_count <= 4'(DATA_BITS));
        // At P=8 the checker answer arrives on the END count itself.
        glitch_now   = glitch_q || (at_res && strt_glitch);
        stp_now      = stp_error || (at_res && stp_err);
    end

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            counter_enable <= 1'b0;
            data_samp_en   <= 1'b0;
            strt_chk_en    <= 1'b0;
            deser_en       <= 1'b0;
            par_chk_en     <= 1'b0;
            stp_chk_en     <= 1'b0;
            data_valid     <= 1'b0;
            par_error      <= 1'b0;
            stp_error      <= 1'b0;
            par_en_q       <= 1'b0;
            glitch_q       <= 1'b0;
        end else begin
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
            if (state != IDLE && (!p_legal || bit_count > stop_idx)) begin
                state          <= IDLE;
                counter_enable <= 1'b0;
                data_samp_en   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!RX_IN && p_legal) begin
                            state          <= START;
                            counter_enable <= 1'b1;
                            data_samp_en   <= 1'b1;
                            par_error      <= 1'b0;
                            stp_error      <= 1'b0;
                            glitch_q       <= 1'b0;
                            par_en_q       <= PAR_EN;
                        end
                    end
                    START: begin
                        if (at_pre_chk) strt_chk_en <= 1'b1;
                        if (at_res && strt_glitch) glitch_q <= 1'b1;
                        if (at_end) begin
                            if (glitch_now) begin
                                state          <= IDLE;
                                counter_enable <= 1'b0;
                                data_samp_en   <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (at_pre_chk && in_data_bits) deser_en <= 1'b1;
                        if (at_end && bit_count == 4'(DATA_BITS))
                            state <= par_en_q ? PARITY : STOP;
                    end
                    PARITY: begin
                        if (at_pre_chk) par_chk_en <= 1'b1;
                        if (at_res && par_err) par_error <= 1'b1;
                        if (at_end) state <= STOP;
                    end
                    STOP: begin
                        if (at_pre_chk) stp_chk_en <= 1'b1;
                        if (at_res && stp_err) stp_error <= 1'b1;
                        if (at_end) begin
                            state          <= IDLE;
                            counter_enable <= 1'b0;
                            data_samp_en   <= 1'b0;
                            data_valid     <= !par_error && !stp_now;
                        end
                    end
                    default: begin
                        state          <= IDLE;
                        counter_enable <= 1'b0;
                        data_samp_en   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with small models of the edge/bit counter,
// the three checkers and the deserializer around it.
module tb_uart_rx_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       counter_enable;
    logic       data_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       par_error;
    logic       stp_error;
    logic [2:0] fsm_state;
    logic [8:0] outs;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         t0;
    int         chk_pos;
    logic       p_ok;
    logic       inj_glitch;
    logic       inj_par;
    logic       inj_stp;
    logic [15:0] line_bits;
    logic [15:0] next_bits;
    logic       next_start;
    logic [7:0] shift_reg;
    logic [7:0] exp_q[$];
    int         valid_cyc[$];
    int         n_deser, n_strt, n_par, n_stp, n_valid, n_samp;
    int         ce_rise;
    logic       ce_prev = 1'b0;

    uart_rx_fsm #(.DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .edge_count(edge_count), .bit_count(bit_count), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .counter_enable(counter_enable),
        .data_samp_en(data_samp_en), .strt_chk_en(strt_chk_en), .deser_en(deser_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .par_error(par_error), .stp_error(stp_error), .fsm_state(fsm_state)
    );

    assign outs = {counter_enable, data_samp_en, strt_chk_en, deser_en, par_chk_en,
                   stp_chk_en, data_valid, par_error, stp_error};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge/bit counter: held at zero while disabled, edge wraps at P-1.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!counter_enable) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (edge_count == 5'(Prescale - 6'd1)) begin
            edge_count <= '0;
            bit_count  <= bit_count + 4'd1;
        end else begin
            edge_count <= edge_count + 5'd1;
        end
    end

    // Checkers answer in the cycle after their strobe.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            strt_glitch <= strt_chk_en & inj_glitch;
            par_err     <= par_chk_en & inj_par;
            stp_err     <= stp_chk_en & inj_stp;
        end
    end

    always @(posedge clk) if (deser_en) shift_reg <= {RX_IN, shift_reg[7:1]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk_pos = int'(Prescale) / 2 + 2;
            p_ok    = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
            if (counter_enable && !ce_prev) ce_rise = cyc;
            if (data_samp_en) n_samp++;
            if (strt_chk_en) begin
                n_strt++;
                if (p_ok) check("strt_chk_pos", 32'(edge_count), chk_pos);
            end
            if (deser_en) begin
                n_deser++;
                if (p_ok) check("deser_pos", 32'(edge_count), chk_pos);
            end
            if (par_chk_en) begin
                n_par++;
                if (p_ok) check("par_chk_pos", 32'(edge_count), chk_pos);
            end
            if (stp_chk_en) begin
                n_stp++;
                if (p_ok) check("stp_chk_pos", 32'(edge_count), chk_pos);
            end
            if (data_valid) begin
                n_valid++;
                valid_cyc.push_back(cyc);
                check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("sb_byte", 32'(shift_reg), 32'(exp_q.pop_front()));
            end
        end
        ce_prev = counter_enable;
    end

    function automatic logic [15:0] frame(input logic [7:0] d, input logic par_on,
                                          input logic par_bit, input logic stop_bit);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (par_on) begin
            f[9]  = par_bit;
            f[10] = stop_bit;
        end else begin
            f[9] = stop_bit;
        end
        return f;
    endfunction

    function automatic int valid_at(input int idx);
        if (valid_cyc.size() > idx) return valid_cyc[idx];
        return -1;
    endfunction

    task automatic clear_stats();
        n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0; n_valid = 0; n_samp = 0;
        ce_rise = -1;
        valid_cyc.delete();
    endtask

    task automatic start_frame(input logic [15:0] bits);
        line_bits = bits;
        @(negedge clk); #1;
        RX_IN = 1'b0;
        t0    = cyc;
    endtask

    // Line follows the frame bits while the counter runs, otherwise idles high.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            if (counter_enable) begin
                RX_IN = line_bits[bit_count];
            end else if (next_start) begin
                RX_IN      = 1'b0;
                next_start = 1'b0;
                line_bits  = next_bits;
            end else begin
                RX_IN = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        inj_glitch = 1'b0; inj_par = 1'b0; inj_stp = 1'b0;
        next_start = 1'b0; next_bits = '1; line_bits = '1; shift_reg = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", 32'(outs), 0);
        check("reset_state", 32'(fsm_state), 0);
        rst = 1'b1;
        run_cycles(3);
        check("idle_outs", 32'(outs), 0);

        // P=8, no parity, 0xA5
        clear_stats();
        exp_q.push_back(8'hA5);
        start_frame(frame(8'hA5, 1'b0, 1'b0, 1'b1));
        run_cycles(85);
        check("t1_ce_rise", ce_rise, t0 + 1);
        check("t1_deser_cnt", n_deser, 8);
        check("t1_strt_cnt", n_strt, 1);
        check("t1_par_cnt", n_par, 0);
        check("t1_stp_cnt", n_stp, 1);
        check("t1_valid_cnt", n_valid, 1);
        check("t1_valid_cyc", valid_at(0), t0 + 81);
        check("t1_samp_cycles", n_samp, 80);
        check("t1_end_outs", 32'(outs), 0);

        // P=16, parity on, 0x3C even parity; PAR_EN dropped mid-frame
        clear_stats();
        Prescale = 6'd16; PAR_EN = 1'b1;
        exp_q.push_back(8'h3C);
        start_frame(frame(8'h3C, 1'b1, 1'b0, 1'b1));
        run_cycles(40);
        PAR_EN = 1'b0;
        run_cycles(141);
        check("t2_par_cnt", n_par, 1);
        check("t2_deser_cnt", n_deser, 8);
        check("t2_valid_cnt", n_valid, 1);
        check("t2_valid_cyc", valid_at(0), t0 + 177);
        check("t2_par_error", 32'(par_error), 0);
        check("t2_samp_cycles", n_samp, 176);

        // P=8, parity error sets the sticky flag and suppresses data_valid
        clear_stats();
        Prescale = 6'd8; PAR_EN = 1'b1; inj_par = 1'b1;
        start_frame(frame(8'h01, 1'b1, 1'b0, 1'b1));
        run_cycles(93);
        inj_par = 1'b0;
        check("t2b_par_error", 32'(par_error), 1);
        check("t2b_stp_error", 32'(stp_error), 0);
        check("t2b_par_cnt", n_par, 1);
        check("t2b_valid_cnt", n_valid, 0);

        // P=8, 2-cycle start glitch
        clear_stats();
        PAR_EN = 1'b0; inj_glitch = 1'b1;
        start_frame(16'hFFFF);
        @(negedge clk); #1;
        RX_IN = 1'b0;
        run_cycles(30);
        inj_glitch = 1'b0;
        check("t3_strt_cnt", n_strt, 1);
        check("t3_deser_cnt", n_deser, 0);
        check("t3_valid_cnt", n_valid, 0);
        check("t3_samp_cycles", n_samp, 8);
        check("t3_state", 32'(fsm_state), 0);
        check("t3_par_error_cleared", 32'(par_error), 0);

        // P=32, parity on, bad stop bit
        clear_stats();
        Prescale = 6'd32; PAR_EN = 1'b1; inj_stp = 1'b1;
        start_frame(frame(8'h96, 1'b1, 1'b0, 1'b0));
        run_cycles(357);
        inj_stp = 1'b0;
        check("t4_stp_error", 32'(stp_error), 1);
        check("t4_par_error", 32'(par_error), 0);
        check("t4_stp_cnt", n_stp, 1);
        check("t4_par_cnt", n_par, 1);
        check("t4_valid_cnt", n_valid, 0);

        // P=16, two frames back-to-back: each is 10*P cycles plus the IDLE cycle
        clear_stats();
        Prescale = 6'd16; PAR_EN = 1'b0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        next_bits  = frame(8'hC3, 1'b0, 1'b0, 1'b1);
        next_start = 1'b1;
        start_frame(frame(8'h5A, 1'b0, 1'b0, 1'b1));
        run_cycles(1);
        check("t5_stp_error_cleared", 32'(stp_error), 0);
        check("t5_ce_on", 32'(counter_enable), 1);
        run_cycles(330);
        check("t5_valid_cnt", n_valid, 2);
        check("t5_first_valid", valid_at(0), t0 + 161);
        check("t5_valid_gap", valid_at(1) - valid_at(0), 161);
        check("t5_deser_cnt", n_deser, 16);
        check("t5_sb_empty", exp_q.size(), 0);

        // P=16 -> 10 mid-DATA aborts; illegal P also blocks a new start
        clear_stats();
        start_frame(frame(8'hFF, 1'b0, 1'b0, 1'b1));
        run_cycles(51);
        Prescale = 6'd10;
        run_cycles(1);
        check("t6a_abort_outs", 32'(outs), 0);
        check("t6a_abort_state", 32'(fsm_state), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            RX_IN = 1'b0;
        end
        check("t6a_illegal_idle", 32'(outs), 0);
        RX_IN = 1'b1;
        Prescale = 6'd16;
        run_cycles(200);
        check("t6a_deser_cnt", n_deser, 2);
        check("t6a_valid_cnt", n_valid, 0);

        // Reset pulsed mid-frame
        clear_stats();
        start_frame(frame(8'h77, 1'b0, 1'b0, 1'b1));
        run_cycles(60);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6b_reset_outs", 32'(outs), 0);
        check("t6b_reset_state", 32'(fsm_state), 0);
        RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        run_cycles(200);
        check("t6b_valid_cnt", n_valid, 0);
        check("t6b_end_outs", 32'(outs), 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
